// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a programmable pattern and don't-care mask,
// an overlap mode, an input qualifier, fill tracking and a saturating match counter.
module seq_detect_param #(
  parameter int                 SEQ_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [SEQ_LEN-1:0] PAT_RST = SEQ_LEN'(8'b1101_1001)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               data,
  input  logic               cfg_load,
  input  logic [SEQ_LEN-1:0] cfg_pattern,
  input  logic [SEQ_LEN-1:0] cfg_mask,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);
  localparam int               FW      = $clog2(SEQ_LEN + 1);
  localparam logic [FW-1:0]    FULL    = FW'(SEQ_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SEQ_LEN-1:0] hist_q, hist_d, pat_q, pat_d, mask_q, mask_d, hist_shift;
  logic [FW-1:0]      fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovl_q, ovl_d, det_q, det_d, sat_q, sat_d, match;

  always_comb begin
    hist_shift = {hist_q[SEQ_LEN-2:0], data};
    fill_inc   = (fill_q == FULL) ? FULL : fill_q + FW'(1);
    // A load in the same cycle discards the data bit, so it can never match.
    match      = in_valid && !cfg_load && (fill_inc == FULL) &&
                 (((hist_shift ^ pat_q) & mask_q) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    mask_d = mask_q;
    ovl_d  = ovl_q;
    if (cfg_load) begin
      hist_d = '0;
      fill_d = '0;
      pat_d  = cfg_pattern;
      mask_d = cfg_mask;
      ovl_d  = cfg_overlap;
    end else if (in_valid) begin
      hist_d = hist_shift;
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
    end

    cnt_d = cnt_q;
    if (count_clr)                     cnt_d = '0;
    else if (match && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    sat_d = (cnt_d == CNT_MAX);
    det_d = match;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PAT_RST;
      mask_q <= '1;
      ovl_q  <= 1'b1;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      mask_q <= mask_d;
      ovl_q  <= ovl_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      det_q  <= det_d;
    end
  end

  assign detected    = det_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;
endmodule
